// File: rtl/trashbin_bus_pkg.sv
// Shared definitions for the Trashbin memory bus: controller states,
// I/O region decode constants and LED register field positions.
package trashbin_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int IO_REGION_BIT = 31;

  localparam logic [3:0] IO_IDX_LED    = 4'd0;
  localparam logic [3:0] IO_IDX_CYCLES = 4'd1;

  // LedReg holds the red LEDs in the low field and the green LEDs above them.
  localparam int LED_REG_WIDTH = 18;
  localparam int LED_LO        = 0;
  localparam int LED_HI        = 9;
  localparam int LEDG_LO       = 10;
  localparam int LEDG_HI       = 17;

endpackage

// File: rtl/trashbin_io_regs.sv
// Memory-mapped I/O registers: the software-owned LED register and a
// free-running, read-only cycle counter, with a read mux by index.
module trashbin_io_regs
  import trashbin_bus_pkg::*;
#(
  parameter logic [31:0] CycleInit = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [3:0]               idx,
  input  logic [LED_REG_WIDTH-1:0] wdata,
  output logic [31:0]              rdata,
  output logic [9:0]               leds,
  output logic [7:0]               leds_g
);

  logic [LED_REG_WIDTH-1:0] led_reg;
  logic [31:0]              cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      led_reg     <= '0;
      cycle_count <= CycleInit;
    end else begin
      cycle_count <= cycle_count + 32'd1;
      if (we) begin
        led_reg <= wdata;
      end
    end
  end

  // Unmapped indices read as zero so software can probe the region safely.
  always_comb begin
    rdata = '0;
    case (idx)
      IO_IDX_LED:    rdata = {{(32-LED_REG_WIDTH){1'b0}}, led_reg};
      IO_IDX_CYCLES: rdata = cycle_count;
      default:       rdata = '0;
    endcase
  end

  assign leds   = led_reg[LED_HI:LED_LO];
  assign leds_g = led_reg[LEDG_HI:LEDG_LO];

endmodule

// File: rtl/trashbin_mem_ctrl.sv
// Bus controller between the Trashbin core memory port and TempRam, turning
// held requests into timed RAM cycles and decoding the I/O register region.
module trashbin_mem_ctrl
  import trashbin_bus_pkg::*;
#(
  parameter int          RamReadLatency = 1,
  parameter int          RamAddrWidth   = 14,
  parameter logic [31:0] CycleInit      = 32'h0000_0000
) (
  input  logic                    CoreClock,
  input  logic                    Reset,
  input  logic [31:0]             AddressBus,
  input  logic [31:0]             DataWriteBus,
  input  logic                    ReadAssert,
  input  logic                    WriteAssert,
  output logic [31:0]             DataReadBus,
  output logic                    ReadOK,
  output logic                    WriteOK,
  output logic [RamAddrWidth-1:0] RamAddress,
  output logic [31:0]             RamData,
  output logic                    RamWrEn,
  input  logic [31:0]             RamQ,
  output logic [9:0]              Leds,
  output logic [7:0]              LedsG
);

  localparam int WaitW = (RamReadLatency < 1) ? 1 : $clog2(RamReadLatency + 1);
  localparam logic [WaitW-1:0] WaitLoad = WaitW'(RamReadLatency);

  state_t           state;
  state_t           state_next;
  logic [WaitW-1:0] wait_cnt;
  logic             is_io;
  logic [3:0]       io_idx;
  logic [31:0]      io_rdata;

  logic accept_wr;
  logic accept_rd;
  logic read_done;
  logic write_done;
  logic io_we;

  // Upper RAM-region address bits are deliberately ignored, so RAM aliases.
  logic unused_addr_bits;
  assign unused_addr_bits = ^AddressBus[30:RamAddrWidth];

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (WriteAssert) begin
          state_next = WR;
        end else if (ReadAssert) begin
          state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (wait_cnt == '0) begin
          state_next = DONE;
        end
      end
      WR:      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write wins over read when both are presented in IDLE.
  always_comb begin
    accept_wr  = (state == IDLE) && WriteAssert;
    accept_rd  = (state == IDLE) && !WriteAssert && ReadAssert;
    read_done  = (state == RD_WAIT) && (wait_cnt == '0);
    write_done = (state == WR);
    RamWrEn    = write_done && !is_io && !Reset;
    io_we      = write_done && is_io && (io_idx == IO_IDX_LED);
  end

  always_ff @(posedge CoreClock) begin
    if (Reset) begin
      DataReadBus <= '0;
      ReadOK      <= 1'b0;
      WriteOK     <= 1'b0;
      RamAddress  <= '0;
      RamData     <= '0;
      wait_cnt    <= '0;
      is_io       <= 1'b0;
      io_idx      <= '0;
    end else begin
      ReadOK  <= read_done;
      WriteOK <= write_done;
      if (accept_wr || accept_rd) begin
        RamAddress <= AddressBus[RamAddrWidth-1:0];
        is_io      <= AddressBus[IO_REGION_BIT];
        io_idx     <= AddressBus[3:0];
      end
      if (accept_wr) begin
        RamData <= DataWriteBus;
      end
      if (accept_rd) begin
        wait_cnt <= WaitLoad;
      end else if ((state == RD_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - WaitW'(1);
      end
      if (read_done) begin
        DataReadBus <= is_io ? io_rdata : RamQ;
      end
    end
  end

  trashbin_io_regs #(
    .CycleInit(CycleInit)
  ) u_io_regs (
    .clk   (CoreClock),
    .reset (Reset),
    .we    (io_we),
    .idx   (io_idx),
    .wdata (RamData[LED_REG_WIDTH-1:0]),
    .rdata (io_rdata),
    .leds  (Leds),
    .leds_g(LedsG)
  );

endmodule

// File: doc/trashbin_mem_ctrl.md
# trashbin_mem_ctrl

Memory-bus controller between the Trashbin core's memory port and the on-chip TempRam. It turns the core's level-held read/write requests into properly timed RAM cycles and returns one-cycle ReadOK/WriteOK completion pulses. It also decodes a small I/O region holding the LED output register and a free-running cycle counter, so the board LEDs become software-controlled instead of wired to debug bits.

## Interface
- RamReadLatency, 1: clocks from the edge where the RAM registers its address to the cycle in which RamQ is valid (≥1).
- RamAddrWidth, 14: RAM word-address width.
- CoreClock  in  1  sole clock; all logic is rising-edge.
- Reset  in  1  synchronous, active-high reset.
- AddressBus  in  32  core address. Bit 31=0 selects RAM (word address [RamAddrWidth-1:0]; bits [30:RamAddrWidth] ignored, so RAM aliases). Bit 31=1 selects I/O (register index [3:0]).
- DataWriteBus  in  32  core write data.
- ReadAssert  in  1  core read request; held high until ReadOK.
- WriteAssert  in  1  core write request; held high until WriteOK.
- DataReadBus  out  32  registered read data; valid while ReadOK=1.
- ReadOK  out  1  one-cycle read-complete pulse.
- WriteOK  out  1  one-cycle write-complete pulse.
- RamAddress  out  RamAddrWidth  latched word address to the RAM.
- RamData  out  32  latched write data to the RAM.
- RamWrEn  out  1  RAM write enable.
- RamQ  in  32  RAM read data.
- Leds  out  10  LedReg[9:0].
- LedsG  out  8  LedReg[17:10].

## Operation
- States: IDLE, RD_WAIT, WR, DONE.
- IDLE: if WriteAssert, latch the address, data and region, then go to WR. Else if ReadAssert, latch the address and region, load WaitCnt=RamReadLatency, then go to RD_WAIT. If both are high, the write wins.
- RD_WAIT: if WaitCnt≠0, decrement it. If WaitCnt=0, capture DataReadBus, set ReadOK=1 and go to DONE. Capture source: RAM region → RamQ. I/O index 0 → LedReg. Index 1 → CycleCount value at the capture edge. Other indices → 0.
- WR: RamWrEn = (state==WR) && region==RAM && !Reset, generated combinationally. An I/O index 0 write loads LedReg at the closing edge. Writes to other I/O indices are ignored. At the closing edge, set WriteOK=1 and go to DONE.
- DONE: ReadOK/WriteOK clear at the next edge, and the state returns to IDLE. Requests are ignored in DONE, so the core must drop or re-present its request after the OK pulse.
- CycleCount: 32-bit, increments every clock, wraps 0xFFFFFFFF→0. It is not writable.
- Reset: state=IDLE, DataReadBus=0, ReadOK=0, WriteOK=0, RamAddress=0, RamData=0, LedReg=0 (Leds=0, LedsG=0), CycleCount=0, WaitCnt=0. RamWrEn=0 combinationally during Reset.
- Reset during RD_WAIT or WR aborts the access: no OK pulse, and no RAM write in the reset cycle.

## Timing
- Let E0 be the accept edge (in IDLE).
- Read: RamAddress is valid from E0. ReadOK is high for the single cycle following edge E0+RamReadLatency+1. With the default, ReadOK follows E2.
- Write: RamWrEn is high for the cycle between E0 and E1. WriteOK is high for the cycle following E1.
- Back-to-back: the next accept is possible no earlier than the edge after the OK cycle. Throughput is one read per RamReadLatency+3 clocks and one write per 3 clocks.
- Requests that appear or change while not in IDLE have no effect.

## Structure
- Package trashbin_bus_pkg: state enum, IO_REGION_BIT=31, IO_IDX_LED=0, IO_IDX_CYCLES=1, LED field positions.
- Sub-module trashbin_io_regs: LedReg, CycleCount, read mux by index and write strobe. The FSM stays in trashbin_mem_ctrl.

## Test plan
- Reset then idle: Leds=0, LedsG=0, ReadOK=0, WriteOK=0, RamWrEn=0 for all reset cycles and afterwards with no requests.
- RAM write then read: write 0xDEADBEEF to address 0x0000_0010. RamWrEn pulses once with RamAddress=0x10, and WriteOK follows E1. Reading 0x10 (RAM model with latency 1) returns 0xDEADBEEF with ReadOK after E2. Repeat with RamReadLatency=3 and check ReadOK after E4.
- I/O: write 0x0003_FFFF to 0x8000_0000 → Leds=0x3FF, LedsG=0xFF, RamWrEn stays 0. Reading 0x8000_0000 returns 0x0003FFFF. Two reads of 0x8000_0001 that are N clocks apart differ by N. Reading 0x8000_0005 returns 0.
- Simultaneous ReadAssert+WriteAssert in IDLE: only a write occurs, WriteOK pulses, ReadOK stays 0.
- Reset asserted during WR: no RamWrEn in the reset cycle, no WriteOK, the RAM location is unchanged. Reset during RD_WAIT: no ReadOK.
- Aliasing and wrap: a write to 0x0000_4010 then a read of 0x0000_0010 returns the written data. The counter preloaded near 0xFFFFFFFF wraps to 0.
